bs_loader: RTL and testbench
============================

# bs_loader

Configuration bitstream transmitter for the neurochip. It accepts configuration bytes over a valid/ready handshake and serializes them MSB-first onto the chain's serial input, asserting the chain's shift enable only when a bit is actually presented. Optionally, it re-circulates the loaded chain once to verify its contents by CRC without disturbing them. It sits on the host/controller side and drives the `config_en` / `bs_in` pins; it receives the chain's `bs_out` tail.

## Interface
Parameters:
- `BS_BITS`, 576: chain length in bits; must be a multiple of `WORD_W` (elaboration-time check).
- `WORD_W`, 8: width of an input configuration word.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored unless `busy`=0.
- `word_data`  in  WORD_W  configuration word; MSB is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  the loader accepts `word_data` this cycle.
- `config_en`  out  1  chain shift enable; the chain samples `bs_in` on the edge ending any cycle where this is high.
- `bs_in`  out  1  serial bit to the chain.
- `bs_ret`  in  1  chain tail bit (chain `bs_out`).
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `done`  out  1  level; high in DONE until the next accepted `start` or `reset`.
- `error`  out  1  readback CRC mismatch; valid while `done`=1.

## Operation
- States: IDLE, LOAD, VERIFY (only with the macro), DONE.
- IDLE -> LOAD on `start`. DONE -> LOAD on `start`; this clears `done` and `error`.
- Datapath: a `WORD_W`-bit shifter with a bit count, plus a one-word holding buffer.
- `word_ready` = LOAD and buffer empty and words accepted < `BS_BITS`/`WORD_W`.
- A word is accepted on any edge where `word_valid` and `word_ready` are both high.
- Placement of an accepted word:
  - If the shifter will be empty after this edge, the word goes directly into the shifter.
  - Otherwise it goes into the buffer.
  - The buffer refills the shifter on the edge at which the shifter's last bit shifts out, so back-to-back words produce no bubble.
- Shift rule:
  - `config_en`=1 and `bs_in`=shifter MSB whenever the shifter holds bits. Each such edge shifts left by one and increments the global bit counter.
  - When the shifter is empty (stall), `config_en`=0 and `bs_in`=0. Bits are never duplicated or dropped.
- LOAD exits when the global counter reaches `BS_BITS`, on the edge that shifts the last bit. The next state is VERIFY if the macro is defined, otherwise DONE.
- Excess `word_valid` after the final word is accepted is not acknowledged.
- Resulting chain order: the first bit sent ends at the far (tail) end of the chain.
- `reset` in any state:
  - Next cycle: state IDLE, `config_en`=0, `word_ready`=0, `busy`=0, `done`=0, `error`=0.
  - Counters, shifter, buffer and CRC are cleared.
  - Chain contents after a mid-load reset are undefined; software must reload.
- Bit counter width: $clog2(`BS_BITS`+1). It never wraps; the terminal count is exact.

## Timing
- `start` at edge N -> LOAD and `word_ready`=1 during cycle N+1.
- Word accepted at edge E with the shifter empty -> `config_en`=1 in cycle E+1, carrying that word's MSB.
- Continuous `word_valid` gives a full load of exactly `BS_BITS` consecutive `config_en` cycles. The first is the cycle after the first acceptance.
- `done` rises in the cycle after the final shift edge (no macro) or after the final VERIFY edge (macro).
- All outputs are registered, except `bs_in` in VERIFY, which is a mux of `bs_ret`. The chain register breaks the loop.

## Configuration
- `BS_READBACK_EN` defined:
  - During LOAD, a CRC-16 (polynomial 0x1021, init 0xFFFF, bit-serial) runs over every shifted bit.
  - VERIFY then holds `config_en`=1 for exactly `BS_BITS` cycles with `bs_in`=`bs_ret`, so the chain recirculates to its original contents. A second CRC runs over `bs_ret`.
  - On exit, `error` = (CRC_load != CRC_ret).
  - Total load-to-`done` time with no stalls: 2×`BS_BITS`+1 cycles after the first acceptance.
- `BS_READBACK_EN` undefined:
  - No VERIFY state and no CRC logic; `error` is tied 0.
  - `bs_ret` is unused.

## Structure
- Package `bs_pkg`: state enum, `CRC_POLY`=16'h1021, `CRC_INIT`=16'hFFFF, default `WORD_W`.
- Sub-module `bs_crc16`: bit-serial CRC with `clk`, `reset`, `clr`, `en`, `din`, `crc[15:0]`. It is instantiated twice under `BS_READBACK_EN`.

## Test plan
- Chain model of 576 bits; 72 words 0x00..0x47 streamed with `word_valid` held high -> `config_en` high for exactly 576 consecutive cycles; model tail bit holds MSB of 0x00; `done`=1 one cycle after the last shift.
- `word_valid` dropped for 5 cycles after word 10 -> exactly 5 `config_en`=0 cycles; final chain image identical to the first test's.
- `BS_READBACK_EN`, clean chain -> VERIFY lasts 576 cycles, `error`=0, chain image unchanged after VERIFY.
- `BS_READBACK_EN`, model flips chain bit 300 before VERIFY -> `error`=1 with `done`=1.
- `reset` asserted at global bit 100 -> next cycle `config_en`=0, `busy`=0, `word_ready`=0; a new `start` performs a full 576-bit load correctly.
- `start` pulsed during LOAD -> ignored; bit count and `done` timing unchanged.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and constants for the configuration bitstream loader:
// FSM state encoding, CRC-16 constants, default word width and a
// single-bit CRC update helper.
package bs_pkg;

    localparam int unsigned WORD_W_DEFAULT = 8;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One step of a bit-serial, MSB-first CRC-16 over CRC_POLY.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/bs_crc16.sv
// Bit-serial CRC-16 accumulator (poly CRC_POLY, init CRC_INIT).
// Ports:
//   clk, reset : clock, synchronous active-high reset (reloads CRC_INIT)
//   clr        : reload CRC_INIT on the next edge (wins over en)
//   en         : fold din into the CRC on the next edge
//   din        : serial data bit
//   crc[15:0]  : current CRC value (registered)
module bs_crc16
    import bs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, din);
        end
    end

    // CRC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/bs_loader.sv
// Configuration bitstream loader: accepts WORD_W-bit words over valid/ready
// and shifts them MSB-first into the configuration chain, raising config_en
// only on cycles that present a real bit. A one-word holding buffer refills
// the shifter on its last-bit edge so streaming words cause no bubble.
// Optional readback (macro BS_READBACK_EN): after loading, the chain is
// recirculated once (bs_in = bs_ret) and a CRC of the returned bits is
// compared against a CRC of the loaded bits; error flags a mismatch.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin a load (honoured only while not busy)
//   word_data/valid/ready : configuration word handshake
//   config_en, bs_in      : chain shift enable and serial data
//   bs_ret                : chain tail bit (used only with BS_READBACK_EN)
//   busy, done, error     : status; error is meaningful while done=1
module bs_loader
    import bs_pkg::*;
#(
    parameter int unsigned BS_BITS = 576,
    parameter int unsigned WORD_W  = WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_en,
    output logic              bs_in,
    input  logic              bs_ret,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned N_WORDS = BS_BITS / WORD_W;
    localparam int unsigned BCNT_W  = $clog2(BS_BITS + 1);
    localparam int unsigned SCNT_W  = $clog2(WORD_W + 1);

    if ((BS_BITS % WORD_W) != 0) begin : g_bad_len
        $error("bs_loader: BS_BITS must be a multiple of WORD_W");
    end

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [SCNT_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic                buf_vld_q, buf_vld_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BCNT_W-1:0]   wcnt_q, wcnt_d;

    logic word_ready_q, word_ready_d;
    logic config_en_q, config_en_d;
    logic bs_in_q, bs_in_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;
    logic load_shift_d;

    logic start_ok;
    logic accept;
    logic shifting;
    logic last_bit;
    logic load_end;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept   = word_valid && word_ready_q;
    assign shifting = (state_q == ST_LOAD) && (sh_cnt_q != '0);
    assign last_bit = shifting && (sh_cnt_q == SCNT_W'(1));
    assign load_end = shifting && (bit_cnt_q == BCNT_W'(BS_BITS - 1));

`ifdef BS_READBACK_EN
    logic        verify_end;
    logic [15:0] crc_load;
    logic [15:0] crc_ret;

    assign verify_end = (state_q == ST_VERIFY) && (bit_cnt_q == BCNT_W'(BS_BITS - 1));

    // CRC over every bit shifted into the chain during LOAD.
    bs_crc16 u_crc_load (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (shifting),
        .din   (sh_q[WORD_W-1]),
        .crc   (crc_load)
    );

    // CRC over the bits returned by the chain tail during VERIFY.
    bs_crc16 u_crc_ret (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (state_q == ST_VERIFY),
        .din   (bs_ret),
        .crc   (crc_ret)
    );
`else
    logic unused_bs_ret;
    assign unused_bs_ret = bs_ret;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_end) begin
`ifdef BS_READBACK_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef BS_READBACK_EN
            ST_VERIFY: begin
                if (verify_end) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (start_ok) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shifter, holding buffer and counters.
    always_comb begin
        sh_d      = sh_q;
        sh_cnt_d  = sh_cnt_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        bit_cnt_d = bit_cnt_q;
        wcnt_d    = wcnt_q;
        if (start_ok) begin
            sh_d      = '0;
            sh_cnt_d  = '0;
            buf_d     = '0;
            buf_vld_d = 1'b0;
            bit_cnt_d = '0;
            wcnt_d    = '0;
        end else begin
            if (shifting) begin
                sh_d      = sh_q << 1;
                sh_cnt_d  = sh_cnt_q - SCNT_W'(1);
                bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end
            // A word goes straight to the shifter if it will be empty after
            // this edge; the buffer is only ever filled behind a busy shifter.
            if (accept) begin
                wcnt_d = wcnt_q + BCNT_W'(1);
                if ((sh_cnt_q == '0) || last_bit) begin
                    sh_d     = word_data;
                    sh_cnt_d = SCNT_W'(WORD_W);
                end else begin
                    buf_d     = word_data;
                    buf_vld_d = 1'b1;
                end
            end else if (last_bit && buf_vld_q) begin
                sh_d      = buf_q;
                sh_cnt_d  = SCNT_W'(WORD_W);
                buf_vld_d = 1'b0;
            end
`ifdef BS_READBACK_EN
            // The bit counter is reused to time the recirculation pass.
            if (load_end) begin
                bit_cnt_d = '0;
            end
            if (state_q == ST_VERIFY) begin
                bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end
`endif
        end
    end

    // Output next values, derived from next state so every output is a flop.
    always_comb begin
        load_shift_d = (state_d == ST_LOAD) && (sh_cnt_d != '0);
        word_ready_d = (state_d == ST_LOAD) && !buf_vld_d && (wcnt_d < BCNT_W'(N_WORDS));
        config_en_d  = load_shift_d;
        bs_in_d      = load_shift_d && sh_d[WORD_W-1];
        busy_d       = (state_d == ST_LOAD);
        done_d       = (state_d == ST_DONE);
        error_d      = 1'b0;
`ifdef BS_READBACK_EN
        if (state_d == ST_VERIFY) begin
            config_en_d = 1'b1;
            busy_d      = 1'b1;
        end
        // The returned CRC still lacks the bit consumed on the final edge.
        error_d = error_q;
        if (start_ok) begin
            error_d = 1'b0;
        end else if (verify_end) begin
            error_d = (crc_load != crc16_step(crc_ret, bs_ret));
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q         <= '0;
            sh_cnt_q     <= '0;
            buf_q        <= '0;
            buf_vld_q    <= 1'b0;
            bit_cnt_q    <= '0;
            wcnt_q       <= '0;
            word_ready_q <= 1'b0;
            config_en_q  <= 1'b0;
            bs_in_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            sh_cnt_q     <= sh_cnt_d;
            buf_q        <= buf_d;
            buf_vld_q    <= buf_vld_d;
            bit_cnt_q    <= bit_cnt_d;
            wcnt_q       <= wcnt_d;
            word_ready_q <= word_ready_d;
            config_en_q  <= config_en_d;
            bs_in_q      <= bs_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign word_ready = word_ready_q;
    assign config_en  = config_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

`ifdef BS_READBACK_EN
    // During VERIFY the chain tail feeds straight back to its head.
    assign bs_in = (state_q == ST_VERIFY) ? bs_ret : bs_in_q;
`else
    assign bs_in = bs_in_q;
`endif

endmodule

// File: tb/tb_bs_loader.sv
// Testbench for bs_loader: random word streams feed a scoreboard queue of
// expected chain bits; a negedge monitor checks every cycle's outputs
// against a bit-pending model and a 576-bit chain model. Covers the
// optional BS_READBACK_EN build when that macro is defined.
module tb_bs_loader;

    localparam int BS = 576;
    localparam int W  = 8;
    localparam int NW = BS / W;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] word_data;
    logic         word_valid;
    logic         word_ready;
    logic         config_en;
    logic         bs_in;
    logic         bs_ret;
    logic         busy;
    logic         done;
    logic         error;

    bs_loader #(.BS_BITS(BS), .WORD_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .config_en  (config_en),
        .bs_in      (bs_in),
        .bs_ret     (bs_ret),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Chain model: head at index 0, tail at index BS-1.
    logic [BS-1:0] chain;
    logic [BS-1:0] chain_nxt;
    assign bs_ret = chain[BS-1];

    int  checks = 0;
    int  errors = 0;
    int  sent, acc, vcnt, stalls;
    bit  active = 1'b0;
    bit  flip_req = 1'b0;
    bit  flip_now = 1'b0;
    bit  exp_err = 1'b0;
    bit  exp_q[$];
    logic [W-1:0] words [NW];
    logic [BS-1:0] img1;

    int m_pend;
    bit e_cen, e_done, e_rdy, e_bit;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_img(input string nm, input logic [BS-1:0] act, input logic [BS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected chain image: stream bit i (word i/W, MSB first) ends at BS-1-i.
    function automatic logic [BS-1:0] image(input bit flip);
        logic [BS-1:0] img;
        logic [W-1:0]  wd;
        for (int i = 0; i < BS; i++) begin
            wd = words[i / W];
            img[BS-1-i] = wd[W-1-(i % W)];
        end
        if (flip) img[300] = ~img[300];
        return img;
    endfunction

    always @(posedge clk) begin
        if (config_en) begin
            chain_nxt = {chain[BS-2:0], bs_in};
            if (flip_now) chain_nxt[300] = ~chain_nxt[300];
            chain <= chain_nxt;
        end
    end

    // Monitor: per-cycle expectations from the pending-bit scoreboard.
    always @(negedge clk) begin
        flip_now = 1'b0;
        if (active) begin
            m_pend = exp_q.size();
            if (sent < BS) begin
                e_cen  = (m_pend > 0);
                e_done = 1'b0;
                e_rdy  = (acc < NW) && (m_pend <= W);
            end else begin
`ifdef BS_READBACK_EN
                if (vcnt < BS) begin
                    e_cen  = 1'b1;
                    e_done = 1'b0;
                    vcnt++;
                end else begin
                    e_cen  = 1'b0;
                    e_done = 1'b1;
                end
`else
                e_cen  = 1'b0;
                e_done = 1'b1;
`endif
                e_rdy = 1'b0;
            end
            chk("config_en", config_en, e_cen);
            chk("done", done, e_done);
            chk("busy", busy, !e_done);
            chk("word_ready", word_ready, e_rdy);
            chk("error", error, e_done && exp_err);
            if (sent < BS) begin
                if (config_en && m_pend > 0) begin
                    e_bit = exp_q.pop_front();
                    chk("bs_in", bs_in, e_bit);
                    sent++;
                    if (sent == BS) flip_now = flip_req;
                end else begin
                    chk("bs_in_stall", bs_in, 1'b0);
                    if (sent > 0) stalls++;
                end
            end else if (e_cen) begin
                chk("bs_in_verify", bs_in, bs_ret);
            end
            if (word_valid && word_ready) begin
                acc++;
                for (int k = W - 1; k >= 0; k--) exp_q.push_back(word_data[k]);
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_config_en"}, config_en, 1'b0);
        chk({tag, "_word_ready"}, word_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
    endtask

    // stall_mode: 0 continuous, 1 five-cycle gap after word 10, 2 random gaps.
    task automatic run_load(input int stall_mode, input int glitch_at, input int abort_at, input bit flip);
        int  idx;
        int  g;
        bit  acc_now;
        bit  glitched;
        exp_q.delete();
        sent = 0; acc = 0; vcnt = 0; stalls = 0;
        flip_req = flip; exp_err = flip;
        glitched = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        active = 1'b1;
        idx = 0; g = 0;
        while (idx < NW && g < 20000) begin
            if (abort_at >= 0 && sent >= abort_at) break;
            word_data  = words[idx];
            word_valid = (stall_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = (glitch_at >= 0) && (idx == glitch_at) && !glitched;
            if (start) glitched = 1'b1;
            @(negedge clk);
            acc_now = word_valid && word_ready;
            @(posedge clk); #1;
            g++;
            if (acc_now) begin
                idx++;
                if (stall_mode == 1 && idx == 10) begin
                    word_valid = 1'b0;
                    start = 1'b0;
                    for (int s = 0; s < 200 && exp_q.size() != 0; s++) begin
                        @(posedge clk); #1;
                    end
                    repeat (4) begin @(posedge clk); #1; end
                end
            end
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            active = 1'b0;
            word_valid = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check_idle("after_reset");
            @(posedge clk); #1;
            return;
        end
        // Keep offering a spare word: it must never be acknowledged.
        word_valid = 1'b1;
        word_data  = W'($urandom);
        g = 0;
        while (!done && g < 4000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("done_reached", done, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        active = 1'b0;
        word_valid = 1'b0;
        chk_int("words_accepted", acc, NW);
        chk_int("bits_sent", sent, BS);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Ramp data, continuous stream.
        for (int i = 0; i < NW; i++) words[i] = W'(i);
        run_load(0, -1, -1, 1'b0);
        chk_int("stalls_continuous", stalls, 0);
        chk("tail_bit", chain[BS-1], words[0][W-1]);
        chk_img("image_ramp", chain, image(1'b0));
        img1 = chain;

        // Same data with a five-cycle gap after word 10.
        run_load(1, -1, -1, 1'b0);
        chk_int("stalls_gap", stalls, 5);
        chk_img("image_gap", chain, img1);

        // Random data, random gaps, stray start during LOAD.
        for (int i = 0; i < NW; i++) words[i] = W'($urandom);
        run_load(2, 30, -1, 1'b0);
        chk_img("image_random", chain, image(1'b0));

        // Reset mid-load, then a clean full load from IDLE.
        for (int i = 0; i < NW; i++) words[i] = W'($urandom);
        run_load(0, -1, 100, 1'b0);
        run_load(0, -1, -1, 1'b0);
        chk_img("image_after_reset", chain, image(1'b0));

`ifdef BS_READBACK_EN
        // Corrupt one chain bit between LOAD and VERIFY.
        for (int i = 0; i < NW; i++) words[i] = W'($urandom);
        run_load(2, -1, -1, 1'b1);
        chk("error_flip", error, 1'b1);
        chk_img("image_flip", chain, image(1'b1));

        run_load(0, -1, -1, 1'b0);
        chk("error_clean", error, 1'b0);
        chk_img("image_clean", chain, image(1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
